// File: rtl/vga_timing_pkg.sv
// Default 832x520 raster geometry (640x480 visible) and the sync/visible bundle
// shared by the timing generator and its alignment delay line.
package vga_timing_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 24;
   localparam int H_SYNC   = 40;
   localparam int H_BACK   = 128;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 9;
   localparam int V_SYNC   = 3;
   localparam int V_BACK   = 28;

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
   } sync_t;

   // Blanked raster: both syncs inactive (high), nothing visible.
   localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0};

endpackage

// File: rtl/vga_timing_sync_delay_line.sv
// ce-gated shift register that carries {hsync, vsync, visible} forward so they
// line up with the renderer's rgb output.
module sync_delay_line
   import vga_timing_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  ce,
   input  sync_t d,
   output sync_t q
);

   sync_t [DEPTH-1:0] stage;

   // NOTE: every stage is reset, not just the output one, so a reset mid-frame
   // cannot let a stale visible=1 drain out of the pipe afterwards.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage <= {DEPTH{SYNC_IDLE}};
      end else if (ce) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster counter for the parallax renderer: undelayed (x, y) and line/frame
// pulses, plus hsync/vsync/visible delayed to match renderer latency.
module vga_timing
   import vga_timing_pkg::sync_t;
#(
   parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
   parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int H_BACK     = vga_timing_pkg::H_BACK,
   parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
   parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int V_BACK     = vga_timing_pkg::V_BACK,
   parameter int PIPE_DELAY = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       line_start,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic       visible
);

   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

   sync_t raw;
   sync_t delayed;

   // NOTE: non-blocking assignments so x and y both update from their
   // pre-edge values; the y wrap test must see the old x.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x <= '0;
         y <= '0;
      end else if (ce) begin
         if (x == H_LAST) begin
            x <= '0;
            y <= (y == V_LAST) ? '0 : y + 10'd1;
         end else begin
            x <= x + 10'd1;
         end
      end
   end

   // NOTE: every field is written on every evaluation, so no latch is inferred.
   always_comb begin
      raw.hsync   = !((x >= HS_START) && (x < HS_END));
      raw.vsync   = !((y >= VS_START) && (y < VS_END));
      raw.visible = (x < H_VIS) && (y < V_VIS);
   end

   // Counters sit at (0,0) throughout reset; the reset term keeps the pulses
   // quiet until the raster actually starts.
   assign line_start  = ce && reset && (x == '0);
   assign frame_start = line_start && (y == '0);

   // The first stage is the comparator register itself, hence the extra one.
   sync_delay_line #(
      .DEPTH(PIPE_DELAY + 1)
   ) u_sync_delay (
      .clk  (clk),
      .reset(reset),
      .ce   (ce),
      .d    (raw),
      .q    (delayed)
   );

   assign hsync   = delayed.hsync;
   assign vsync   = delayed.vsync;
   assign visible = delayed.visible;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: three instances (full raster with delay 0
// and 3, small raster with delay 2) compared against a ce-count raster model.
module tb_vga_timing;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, pd;
   } geom_t;

   localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 5;
   localparam int SV_A = 6,  SV_F = 2, SV_S = 2, SV_B = 3;
   localparam int FRAME_S = 338;   // 26 dots x 13 lines

   logic clk, reset, ce;
   logic [9:0] x_0, y_0, x_3, y_3, x_s, y_s;
   logic ls_0, fs_0, hs_0, vs_0, vis_0;
   logic ls_3, fs_3, hs_3, vs_3, vis_3;
   logic ls_s, fs_s, hs_s, vs_s, vis_s;

   int tests = 0;
   int fails = 0;
   longint n = 0;          // ce edges taken since reset release
   longint clk_cnt = 0;
   geom_t g0, g3, gs;

   bit first_run = 0, alt_mode = 0;
   int vis_cnt = 0, hs_low_cnt = 0;
   longint fall0 = -1, fall3 = -1, last_fs = -1, last_ls_clk = -1;
   logic prev_hs0 = 1'b1, prev_hs3 = 1'b1;

   vga_timing #(.PIPE_DELAY(0)) dut0 (
      .clk(clk), .reset(reset), .ce(ce), .x(x_0), .y(y_0),
      .line_start(ls_0), .frame_start(fs_0), .hsync(hs_0), .vsync(vs_0), .visible(vis_0)
   );

   vga_timing #(.PIPE_DELAY(3)) dut3 (
      .clk(clk), .reset(reset), .ce(ce), .x(x_3), .y(y_3),
      .line_start(ls_3), .frame_start(fs_3), .hsync(hs_3), .vsync(vs_3), .visible(vis_3)
   );

   vga_timing #(
      .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
      .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
      .PIPE_DELAY(2)
   ) duts (
      .clk(clk), .reset(reset), .ce(ce), .x(x_s), .y(y_s),
      .line_start(ls_s), .frame_start(fs_s), .hsync(hs_s), .vsync(vs_s), .visible(vis_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int htot(geom_t g);
      return g.ha + g.hf + g.hs + g.hb;
   endfunction

   function automatic int vtot(geom_t g);
      return g.va + g.vf + g.vs + g.vb;
   endfunction

   // {hsync, vsync, visible} for the m-th dot of the raster.
   function automatic logic [2:0] rules(geom_t g, longint m);
      longint px, py;
      logic h, v, vis;
      px  = m % htot(g);
      py  = (m / htot(g)) % vtot(g);
      h   = !(px >= g.ha + g.hf && px < g.ha + g.hf + g.hs);
      v   = !(py >= g.va + g.vf && py < g.va + g.vf + g.vs);
      vis = (px < g.ha) && (py < g.va);
      return {h, v, vis};
   endfunction

   function automatic logic [2:0] exp_sync(geom_t g);
      logic [2:0] r;
      if (n < 1 + g.pd) r = 3'b110;
      else              r = rules(g, n - 1 - g.pd);
      return r;
   endfunction

   function automatic logic exp_vis(geom_t g);
      logic [2:0] r;
      r = exp_sync(g);
      return r[0];
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string name, input geom_t g,
                            input logic [9:0] dx, input logic [9:0] dy,
                            input logic dls, input logic dfs,
                            input logic dhs, input logic dvs, input logic dvis);
      longint ex, ey;
      logic [2:0] es;
      logic els;
      ex  = n % htot(g);
      ey  = (n / htot(g)) % vtot(g);
      es  = exp_sync(g);
      els = (ce === 1'b1) && (ex == 0);
      check({name, ".x"}, longint'(dx), ex);
      check({name, ".y"}, longint'(dy), ey);
      check({name, ".line_start"}, longint'(dls), longint'(els));
      check({name, ".frame_start"}, longint'(dfs), longint'(els && (ey == 0)));
      check({name, ".hsync"}, longint'(dhs), longint'(es[2]));
      check({name, ".vsync"}, longint'(dvs), longint'(es[1]));
      check({name, ".visible"}, longint'(dvis), longint'(es[0]));
      check({name, ".vis_in_sync"}, longint'(dvis & (~dhs | ~dvs)), 0);
   endtask

   task automatic check_idle(input string name,
                             input logic [9:0] dx, input logic [9:0] dy,
                             input logic dls, input logic dfs,
                             input logic dhs, input logic dvs, input logic dvis);
      check({name, ".rst_x"}, longint'(dx), 0);
      check({name, ".rst_y"}, longint'(dy), 0);
      check({name, ".rst_line_start"}, longint'(dls), 0);
      check({name, ".rst_frame_start"}, longint'(dfs), 0);
      check({name, ".rst_hsync"}, longint'(dhs), 1);
      check({name, ".rst_vsync"}, longint'(dvs), 1);
      check({name, ".rst_visible"}, longint'(dvis), 0);
   endtask

   task automatic check_all_idle();
      check_idle("d0", x_0, y_0, ls_0, fs_0, hs_0, vs_0, vis_0);
      check_idle("d3", x_3, y_3, ls_3, fs_3, hs_3, vs_3, vis_3);
      check_idle("ds", x_s, y_s, ls_s, fs_s, hs_s, vs_s, vis_s);
   endtask

   // One clock: drive ce at the falling edge, check mid-cycle, then take the edge.
   task automatic step(input logic v);
      @(negedge clk);
      ce = v;
      #1;
      check_dut("d0", g0, x_0, y_0, ls_0, fs_0, hs_0, vs_0, vis_0);
      check_dut("d3", g3, x_3, y_3, ls_3, fs_3, hs_3, vs_3, vis_3);
      check_dut("ds", gs, x_s, y_s, ls_s, fs_s, hs_s, vs_s, vis_s);
      if (first_run && v && n >= 1 && n <= 832) begin
         if (vis_0) vis_cnt++;
         if (!hs_0) hs_low_cnt++;
      end
      if (first_run && prev_hs0 && !hs_0 && fall0 < 0) fall0 = n;
      if (first_run && prev_hs3 && !hs_3 && fall3 < 0) fall3 = n;
      prev_hs0 = hs_0;
      prev_hs3 = hs_3;
      if (fs_s) begin
         if (last_fs >= 0) check("ds.frame_period", n - last_fs, FRAME_S);
         last_fs = n;
      end
      if (alt_mode && ls_0) begin
         if (last_ls_clk >= 0) check("d0.line_clocks_half_ce", clk_cnt - last_ls_clk, 1664);
         last_ls_clk = clk_cnt;
      end
      @(posedge clk);
      if (v) n++;
      clk_cnt++;
   endtask

   initial begin
      logic [9:0] xa;
      g0 = '{ha: vga_timing_pkg::H_ACTIVE, hf: vga_timing_pkg::H_FRONT,
             hs: vga_timing_pkg::H_SYNC,   hb: vga_timing_pkg::H_BACK,
             va: vga_timing_pkg::V_ACTIVE, vf: vga_timing_pkg::V_FRONT,
             vs: vga_timing_pkg::V_SYNC,   vb: vga_timing_pkg::V_BACK, pd: 0};
      g3 = g0;
      g3.pd = 3;
      gs = '{ha: SH_A, hf: SH_F, hs: SH_S, hb: SH_B,
             va: SV_A, vf: SV_F, vs: SV_S, vb: SV_B, pd: 2};

      // Reset held with ce active: everything idle, no pulses.
      reset = 1'b0;
      ce    = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check_all_idle();
      end

      // Release between edges; the first checked cycle is (0,0) with both pulses.
      @(posedge clk);
      #2;
      reset = 1'b1;
      n = 0;
      first_run = 1;
      for (int i = 0; i < 2000; i++) step(1'b1);
      first_run = 0;
      check("d0.visible_per_line", vis_cnt, 640);
      check("d0.hsync_low_per_line", hs_low_cnt, 40);
      check("d0.hsync_fall_n", fall0, 665);
      check("d3.hsync_fall_n", fall3, 668);

      // Random pixel enable.
      for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)));

      // ce = 1,0,0,1 advances x by exactly two.
      #1;
      xa = x_0;
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b1);
      #1;
      check("d0.x_adv_ce1001", (longint'(x_0) + 832 - longint'(xa)) % 832, 2);

      // 50% ce: line_start spacing in clocks.
      alt_mode = 1;
      for (int i = 0; i < 3600; i++) step(i % 2 == 0);
      alt_mode = 0;

      // Run until visible data is in flight, then reset asynchronously mid-cycle.
      for (int i = 0; i < 400 && !(exp_vis(gs) && exp_vis(g0)); i++) step(1'b1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_all_idle();
      repeat (3) begin
         @(negedge clk);
         #1;
         check_all_idle();
      end
      n = 0;
      last_fs = -1;
      @(posedge clk);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
